serial_adder: RTL

//   Bit-serial adder; the additive counterpart of the team's half-subtractor path. Reconstructs
//   a + b from operand pairs. Accepts WIDTH-bit operands over a valid/ready handshake.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 20 ++
 rtl/serial_adder.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared FSM encoding and defaults for the serial arithmetic blocks
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder built from two half-adder stages
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  assign hs1 = a ^ b;
  assign hc1 = a & b;
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder with valid/ready operand and result handshakes
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign in_ready = (state == IDLE);
  // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at sum_sr[0].
  assign sum      = sum_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      count     <= '0;
      carry     <= 1'b0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          carry  <= fa_co;
          count  <= count + 1'b1;
          if (count == LAST_BIT) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // Here carry is the carry into the MSB and fa_co the carry out of it.
            ovf       <= carry ^ fa_co;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
